// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode-stage operand unit.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   sel_t               : operand source select (register file, WB, MEM, EXE)
//   ZERO_REG            : index of the hard-wired zero register
package id_operand_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_WB  = 2'd1,
        SEL_MEM = 2'd2,
        SEL_EXE = 2'd3
    } sel_t;

endpackage

// File: rtl/id_operand_stage_gpr_file.sv
// General register file: NREG x XLEN, two combinational read ports, one write port.
//   clk, reset          : clock, synchronous active-high reset (clears all registers)
//   we, waddr, wdata    : write port; writes to the zero register are dropped
//   raddr_a/b, rdata_a/b: read ports; index 0 always reads 0
// WRITE_THROUGH=1 makes a same-cycle write visible on the read ports.
module gpr_file
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int NREG          = NREG_DEF,
    parameter int WRITE_THROUGH = 1,
    localparam int AW           = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != AW'(ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] addr);
        if (addr == AW'(ZERO_REG))
            return '0;
        else if (WRITE_THROUGH != 0 && we && waddr == addr)
            return wdata;
        else
            return regs[addr];
    endfunction

    assign rdata_a = rd(raddr_a);
    assign rdata_b = rd(raddr_b);

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: register file, EXE/MEM/WB bypass, hazard stall,
// rs==rt branch compare and the ID/EX pipeline register.
//   in_*       : decoded instruction and its valid/ready handshake
//   exe_*/mem_*: in-flight destinations and results used for bypass and hazards
//   wb_*       : register-file write port
//   flush      : kills the ID instruction and the ID/EX register
//   out_*      : ID/EX register contents with valid/ready handshake
//   rs_eq_rt   : compare of the bypassed operands (only meaningful when !stall)
//   stall      : hazard stall; stall_cycles counts them, saturating
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 32,
    localparam int AW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic [AW-1:0]    in_rn,
    input  logic             in_wen,
    input  logic             in_is_load,
    input  logic             in_uses_rs,
    input  logic             in_uses_rt,
    input  logic             in_is_branch,
    input  logic             exe_wen,
    input  logic             exe_is_load,
    input  logic [AW-1:0]    exe_rn,
    input  logic [XLEN-1:0]  exe_result,
    input  logic             mem_wen,
    input  logic             mem_is_load,
    input  logic [AW-1:0]    mem_rn,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_wen,
    input  logic [AW-1:0]    wb_rn,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [AW-1:0]    out_rn,
    output logic             out_wen,
    output logic             out_is_load,
    output logic             rs_eq_rt,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [XLEN-1:0] rf_a, rf_b, op_a, op_b;
    sel_t            sel_a, sel_b;
    logic            exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic            load_en;

    gpr_file #(
        .XLEN          (XLEN),
        .NREG          (NREG),
        .WRITE_THROUGH (WB_BYPASS)
    ) u_gpr (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_wen),
        .waddr   (wb_rn),
        .wdata   (wb_data),
        .raddr_a (in_rs),
        .raddr_b (in_rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    function automatic logic hit(input logic wen, input logic [AW-1:0] rn,
                                 input logic [AW-1:0] r);
        return wen && rn == r && r != AW'(ZERO_REG);
    endfunction

    function automatic sel_t pick(input logic eh, input logic mh, input logic wh);
        // An EXE load has no data yet; it falls through (and stalls if used).
        if (eh && !exe_is_load)           return SEL_EXE;
        else if (mh)                      return SEL_MEM;
        else if (wh && WB_BYPASS != 0)    return SEL_WB;
        else                              return SEL_RF;
    endfunction

    function automatic logic [XLEN-1:0] mux(input sel_t s, input logic [XLEN-1:0] rf);
        case (s)
            SEL_EXE: return exe_result;
            SEL_MEM: return mem_result;
            SEL_WB:  return wb_data;
            default: return rf;
        endcase
    endfunction

    always_comb begin
        exe_hit_a = hit(exe_wen, exe_rn, in_rs);
        exe_hit_b = hit(exe_wen, exe_rn, in_rt);
        mem_hit_a = hit(mem_wen, mem_rn, in_rs);
        mem_hit_b = hit(mem_wen, mem_rn, in_rt);
        wb_hit_a  = hit(wb_wen,  wb_rn,  in_rs);
        wb_hit_b  = hit(wb_wen,  wb_rn,  in_rt);
        sel_a     = pick(exe_hit_a, mem_hit_a, wb_hit_a);
        sel_b     = pick(exe_hit_b, mem_hit_b, wb_hit_b);
        op_a      = mux(sel_a, rf_a);
        op_b      = mux(sel_b, rf_b);
    end

    assign stall = in_valid && (
          (in_uses_rs && exe_hit_a && (exe_is_load || in_is_branch))
       || (in_uses_rt && exe_hit_b && (exe_is_load || in_is_branch))
       || (in_is_branch && mem_is_load && ((in_uses_rs && mem_hit_a) || (in_uses_rt && mem_hit_b))));

    assign rs_eq_rt = (op_a == op_b);
    assign in_ready = flush || (!stall && (!out_valid || out_ready));
    assign load_en  = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_rn      <= '0;
            out_wen     <= 1'b0;
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid   <= 1'b1;
            out_a       <= op_a;
            out_b       <= op_b;
            out_rn      <= in_rn;
            out_wen     <= in_wen;
            out_is_load <= in_is_load;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !flush && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
